apu_voice_bank: RTL and testbench

//   Parametrised N-channel tone generator for the APU: per-channel pulse (4 duties) or LFSR-noise voice,

---
 rtl/apu_pkg.sv | 24 ++
 rtl/apu_voice.sv | 74 +++++++
 rtl/apu_voice_bank.sv | 79 +++++++
 tb/tb_apu_voice_bank.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared constants for the APU voice bank: register map, CTRL bit positions,
// pulse duty patterns and the noise LFSR seed.
package apu_pkg;

   typedef enum logic [1:0] {
      REG_PERIOD = 2'd0,
      REG_DUTY   = 2'd1,
      REG_VOLUME = 2'd2,
      REG_CTRL   = 2'd3
   } reg_addr_e;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;

   localparam logic [14:0] LFSR_SEED = 15'h0001;

   // Entry [d] is the 8-step waveform for duty code d; bit s is the level at step s.
   localparam logic [3:0][7:0] DUTY_TABLE = {8'b1111_1100, 8'b0000_1111, 8'b0000_0011, 8'b0000_0001};

   function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
      return DUTY_TABLE[duty][step];
   endfunction

endpackage

// File: rtl/apu_voice.sv
// One APU voice: register set, period down-counter, 8-step pulse sequencer and
// 15-bit noise LFSR. o_amp reflects the state after the advance of the current tick.
module apu_voice
   import apu_pkg::*;
#(
   parameter int PERIOD_W = 12,
   parameter int VOL_W    = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_tick,
   input  logic                i_we,
   input  logic [1:0]          i_addr,
   input  logic [PERIOD_W-1:0] i_data,
   output logic [VOL_W-1:0]    o_amp
);

   logic [PERIOD_W-1:0] r_per;
   logic [PERIOD_W-1:0] r_cnt;
   logic [1:0]          r_duty;
   logic [VOL_W-1:0]    r_vol;
   logic                r_en;
   logic                r_mode;
   logic [2:0]          r_step;
   logic [14:0]         r_lfsr;

   logic                w_run;
   logic                w_wrap;
   logic [2:0]          w_step_nx;
   logic [14:0]         w_lfsr_nx;
   logic                w_level;

   assign w_run     = r_en && (r_per != '0);
   assign w_wrap    = i_tick && w_run && (r_cnt == '0);
   assign w_step_nx = (w_wrap && !r_mode) ? r_step + 3'd1 : r_step;
   assign w_lfsr_nx = (w_wrap && r_mode) ? {r_lfsr[0] ^ r_lfsr[1], r_lfsr[14:1]} : r_lfsr;
   assign w_level   = r_mode ? ~w_lfsr_nx[0] : duty_bit(r_duty, w_step_nx);
   assign o_amp     = (w_run && w_level) ? r_vol : '0;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_per  <= '0;
         r_cnt  <= '0;
         r_duty <= '0;
         r_vol  <= '0;
         r_en   <= 1'b0;
         r_mode <= 1'b0;
         r_step <= '0;
         r_lfsr <= LFSR_SEED;
      end else if (i_we) begin
         case (reg_addr_e'(i_addr))
            REG_PERIOD: r_per  <= i_data;
            REG_DUTY:   r_duty <= i_data[1:0];
            REG_VOLUME: r_vol  <= i_data[VOL_W-1:0];
            REG_CTRL: begin
               r_mode <= i_data[CTRL_MODE];
               r_en   <= i_data[CTRL_EN];
               // Only a real enable transition restarts the voice.
               if (i_data[CTRL_EN] != r_en) begin
                  r_step <= '0;
                  r_cnt  <= r_per;
                  r_lfsr <= LFSR_SEED;
               end
            end
            default: ;
         endcase
      end else if (i_tick && w_run) begin
         r_cnt  <= (r_cnt == '0) ? r_per : r_cnt - 1'b1;
         r_step <= w_step_nx;
         r_lfsr <= w_lfsr_nx;
      end
   end

endmodule

// File: rtl/apu_voice_bank.sv
// N-voice APU tone bank: tick prescaler, register-write handshake and decode,
// per-voice instances and the mixer producing one registered PCM sample per tick.
module apu_voice_bank
   import apu_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int PERIOD_W = 12,
   parameter int VOL_W    = 4,
   parameter int PRESCALE = 16,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int OUT_W   = VOL_W + $clog2(NUM_CH)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_wr_valid,
   output logic                o_wr_ready,
   input  logic [CH_W-1:0]     i_wr_ch,
   input  logic [1:0]          i_wr_addr,
   input  logic [PERIOD_W-1:0] i_wr_data,
   output logic [OUT_W-1:0]    o_sample,
   output logic                o_sample_valid
);

   localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0]  r_presc;
   logic             w_tick;
   logic             w_acc;
   logic [VOL_W-1:0] w_amp [NUM_CH];
   logic [OUT_W-1:0] w_sum;

   assign w_tick     = (r_presc == '0);
   assign o_wr_ready = !i_rst && !w_tick;
   assign w_acc      = i_wr_valid && o_wr_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_presc <= '0;
      end else begin
         r_presc <= w_tick ? PS_W'(PRESCALE - 1) : r_presc - 1'b1;
      end
   end

   // Out-of-range channel numbers match no voice, so the write is simply dropped.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
      apu_voice #(
         .PERIOD_W (PERIOD_W),
         .VOL_W    (VOL_W)
      ) u_voice (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_tick (w_tick),
         .i_we   (w_acc && (i_wr_ch == CH_W'(g))),
         .i_addr (i_wr_addr),
         .i_data (i_wr_data),
         .o_amp  (w_amp[g])
      );
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_sum = w_sum + OUT_W'(w_amp[i]);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_sample       <= '0;
         o_sample_valid <= 1'b0;
      end else begin
         o_sample_valid <= w_tick;
         if (w_tick) begin
            o_sample <= w_sum;
         end
      end
   end

endmodule

// File: tb/tb_apu_voice_bank.sv
// Randomised bench for apu_voice_bank: a tick-level behavioural model of the
// voices predicts wr_ready, sample_valid and sample on every clock.
module tb_apu_voice_bank;

   localparam int NUM_CH   = 4;
   localparam int PERIOD_W = 12;
   localparam int VOL_W    = 4;
   localparam int PRESCALE = 4;
   localparam int OUT_W    = VOL_W + $clog2(NUM_CH);

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                wr_valid = 1'b0;
   logic                wr_ready;
   logic [1:0]          wr_ch = '0;
   logic [1:0]          wr_addr = '0;
   logic [PERIOD_W-1:0] wr_data = '0;
   logic [OUT_W-1:0]    sample;
   logic                sample_valid;

   apu_voice_bank #(
      .NUM_CH   (NUM_CH),
      .PERIOD_W (PERIOD_W),
      .VOL_W    (VOL_W),
      .PRESCALE (PRESCALE)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_wr_valid     (wr_valid),
      .o_wr_ready     (wr_ready),
      .i_wr_ch        (wr_ch),
      .i_wr_addr      (wr_addr),
      .i_wr_data      (wr_data),
      .o_sample       (sample),
      .o_sample_valid (sample_valid)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: per-voice registers plus position within the waveform.
   int m_per [NUM_CH];
   int m_duty[NUM_CH];
   int m_vol [NUM_CH];
   int m_en  [NUM_CH];
   int m_mode[NUM_CH];
   int m_cnt [NUM_CH];
   int m_step[NUM_CH];
   int m_lfsr[NUM_CH];
   int m_sample;
   int cyc;
   int dut_max, mod_max;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_per[c] = 0; m_duty[c] = 0; m_vol[c] = 0; m_en[c] = 0; m_mode[c] = 0;
         m_cnt[c] = 0; m_step[c] = 0; m_lfsr[c] = 1;
      end
      m_sample = 0;
      cyc = 0;
   endtask

   function automatic bit pulse_high(input int duty, input int step);
      case (duty)
         0:       return step == 0;
         1:       return step < 2;
         2:       return step < 4;
         default: return step >= 2;
      endcase
   endfunction

   task automatic model_tick();
      int sum;
      sum = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (m_en[c] != 0 && m_per[c] != 0) begin
            if (m_cnt[c] == 0) begin
               m_cnt[c] = m_per[c];
               if (m_mode[c] != 0)
                  m_lfsr[c] = (m_lfsr[c] >> 1) | (((m_lfsr[c] ^ (m_lfsr[c] >> 1)) & 1) << 14);
               else
                  m_step[c] = (m_step[c] + 1) % 8;
            end else begin
               m_cnt[c] = m_cnt[c] - 1;
            end
            if (m_mode[c] != 0 ? (m_lfsr[c] & 1) == 0 : pulse_high(m_duty[c], m_step[c]))
               sum += m_vol[c];
         end
      end
      m_sample = sum;
   endtask

   task automatic model_write(input int ch, input int addr, input int data);
      int en;
      case (addr)
         0: m_per[ch]  = data % 4096;
         1: m_duty[ch] = data % 4;
         2: m_vol[ch]  = data % 16;
         default: begin
            en = data & 1;
            if (en != m_en[ch]) begin
               m_step[ch] = 0;
               m_cnt[ch]  = m_per[ch];
               m_lfsr[ch] = 1;
            end
            m_en[ch]   = en;
            m_mode[ch] = (data >> 1) & 1;
         end
      endcase
   endtask

   // One clock: check ready before the edge, advance the model, check outputs after.
   task automatic step(output bit acc);
      bit tk;
      tk  = (cyc % PRESCALE) == 0;
      chk("wr_ready", wr_ready, !tk);
      acc = wr_valid && !tk;
      @(posedge clk);
      #1;
      cyc++;
      if (tk) model_tick();
      else if (acc) model_write(wr_ch, wr_addr, wr_data);
      chk("sample_valid", sample_valid, tk);
      chk("sample", sample, m_sample);
      if (tk) begin
         if (int'(sample) > dut_max) dut_max = sample;
         if (m_sample > mod_max) mod_max = m_sample;
      end
   endtask

   task automatic run(input int n);
      bit a;
      repeat (n) step(a);
   endtask

   task automatic wr(input int ch, input int addr, input int data);
      bit a;
      bit done;
      done     = 0;
      wr_valid = 1'b1;
      wr_ch    = 2'(ch);
      wr_addr  = 2'(addr);
      wr_data  = PERIOD_W'(data);
      for (int i = 0; i < 8 && !done; i++) begin
         step(a);
         done = a;
      end
      wr_valid = 1'b0;
      if (!done) chk("wr_timeout", 0, 1);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      chk("rst_sample", sample, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_ready", wr_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
   endtask

   initial begin
      bit a;
      model_reset();
      dut_max = 0;
      mod_max = 0;
      apply_reset();
      run(12);

      // Single 50% pulse voice at full volume.
      wr(0, 0, 2); wr(0, 1, 2); wr(0, 2, 15); wr(0, 3, 1);
      run(200);

      // All voices 75% duty; ch3 frozen at period 0, then running at period 1.
      for (int c = 0; c < NUM_CH; c++) begin
         wr(c, 1, 3); wr(c, 2, 15); wr(c, 0, (c == 3) ? 0 : 2); wr(c, 3, 1);
      end
      dut_max = 0; mod_max = 0;
      run(300);
      chk("max_ch3_frozen", dut_max, mod_max);
      wr(3, 0, 1);
      dut_max = 0; mod_max = 0;
      run(300);
      chk("max_all", dut_max, mod_max);

      // Period rewrite mid-count on ch0; redundant enable rewrite.
      run(5);
      wr(0, 0, 5);
      wr(0, 3, 1);
      run(200);

      // Noise voice on ch1 alone, then restart via disable/enable.
      apply_reset();
      run(4);
      wr(1, 0, 0); wr(1, 0, 1); wr(1, 2, 8); wr(1, 3, 3);
      run(600);
      wr(1, 3, 2); run(20); wr(1, 3, 3);
      run(400);

      // Held-valid handshake: new data presented every cycle.
      wr_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         wr_ch   = 2'($urandom_range(0, NUM_CH - 1));
         wr_addr = 2'($urandom_range(1, 2));
         wr_data = PERIOD_W'($urandom);
         step(a);
      end
      wr_valid = 1'b0;
      run(40);

      // Randomised register traffic.
      for (int i = 0; i < 250; i++) begin
         int ad;
         ad = $urandom_range(0, 3);
         run($urandom_range(0, 12));
         wr($urandom_range(0, NUM_CH - 1), ad, (ad == 0) ? $urandom_range(0, 4) : $urandom);
      end
      run(100);

      // Mid-run reset and recovery.
      apply_reset();
      run(40);
      wr(2, 0, 1); wr(2, 1, 0); wr(2, 2, 9); wr(2, 3, 1);
      run(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=%0d exp=%0d", 0, 1);
      $fatal(1, "timeout");
   end

endmodule
